// File: rtl/p4_router_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : p4_router_pkg                                                   |
// | Brief    : Shared widths and arbiter state encoding for the ingress path.  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package p4_router_pkg;

    localparam int AXIS_DATA_W = 64;
    localparam int AXIS_KEEP_W = 8;
    localparam int PKT_CNT_W   = 32;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PKT  = 1'b1
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/p4_router_axis_skid.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : p4_router_axis_skid                                             |
// | Brief    : Two-entry AXI-Stream register slice, full throughput, with      |
// |            registered upstream ready.                                      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module p4_router_axis_skid
    import p4_router_pkg::*;
#(
    parameter int META_W = 19
) (
    input  logic                   clk,
    input  logic                   aresetn,
    input  logic                   i_s_valid,
    output logic                   o_s_ready,
    input  logic [AXIS_DATA_W-1:0] i_s_data,
    input  logic [AXIS_KEEP_W-1:0] i_s_keep,
    input  logic                   i_s_last,
    input  logic [META_W-1:0]      i_s_meta,
    input  logic                   i_s_meta_valid,
    output logic                   o_m_valid,
    input  logic                   i_m_ready,
    output logic [AXIS_DATA_W-1:0] o_m_data,
    output logic [AXIS_KEEP_W-1:0] o_m_keep,
    output logic                   o_m_last,
    output logic [META_W-1:0]      o_m_meta,
    output logic                   o_m_meta_valid
);

    localparam int c_PAY_W = AXIS_DATA_W + AXIS_KEEP_W + 1 + META_W + 1;

    logic [c_PAY_W-1:0] w_in_pay;
    logic [c_PAY_W-1:0] r_out_pay;
    logic [c_PAY_W-1:0] r_skid_pay;
    logic               r_out_valid;
    logic               r_skid_valid;

    assign w_in_pay  = {i_s_data, i_s_keep, i_s_last, i_s_meta, i_s_meta_valid};
    assign o_s_ready = !r_skid_valid;
    assign o_m_valid = r_out_valid;
    assign {o_m_data, o_m_keep, o_m_last, o_m_meta, o_m_meta_valid} = r_out_pay;

    // The skid entry only fills when the output is stalled while a beat is
    // accepted; it drains into the output register before new input is taken.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_out_pay    <= '0;
            r_skid_pay   <= '0;
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (i_m_ready || !r_out_valid) begin
            if (r_skid_valid) begin
                r_out_pay    <= r_skid_pay;
                r_out_valid  <= 1'b1;
                r_skid_valid <= 1'b0;
            end else begin
                r_out_valid <= i_s_valid;
                if (i_s_valid) begin
                    r_out_pay <= w_in_pay;
                end
            end
        end else if (i_s_valid && !r_skid_valid) begin
            r_skid_pay   <= w_in_pay;
            r_skid_valid <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/p4_router_ingress_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : p4_router_ingress_arbiter                                       |
// | Brief    : Packet-level round-robin arbiter feeding the VNP4 data input;   |
// |            stamps the ingress port into the first-beat metadata.           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module p4_router_ingress_arbiter
    import p4_router_pkg::*;
#(
    parameter int NUM_PORTS           = 4,
    parameter int USER_METADATA_WIDTH = 19,
    parameter int PORT_ID_LSB         = 0
) (
    input  logic                                           clk,
    input  logic                                           aresetn,
    input  logic [NUM_PORTS-1:0][AXIS_DATA_W-1:0]          s_tdata,
    input  logic [NUM_PORTS-1:0][AXIS_KEEP_W-1:0]          s_tkeep,
    input  logic [NUM_PORTS-1:0]                           s_tlast,
    input  logic [NUM_PORTS-1:0]                           s_tvalid,
    output logic [NUM_PORTS-1:0]                           s_tready,
    input  logic [NUM_PORTS-1:0][USER_METADATA_WIDTH-1:0]  s_meta,
    input  logic [NUM_PORTS-1:0]                           port_enable,
    output logic [AXIS_DATA_W-1:0]                         m_tdata,
    output logic [AXIS_KEEP_W-1:0]                         m_tkeep,
    output logic                                           m_tlast,
    output logic                                           m_tvalid,
    input  logic                                           m_tready,
    output logic [USER_METADATA_WIDTH-1:0]                 m_meta,
    output logic                                           m_meta_valid,
    output logic [NUM_PORTS-1:0][PKT_CNT_W-1:0]            pkt_count
);

    localparam int c_PORT_ID_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    arb_state_t                             r_state;
    arb_state_t                             w_state_nxt;
    logic [c_PORT_ID_W-1:0]                 r_grant;
    logic [c_PORT_ID_W-1:0]                 w_grant_nxt;
    logic [c_PORT_ID_W-1:0]                 r_last_grant;
    logic [c_PORT_ID_W-1:0]                 w_last_grant_nxt;
    logic                                   r_first;
    logic                                   w_first_nxt;
    logic [NUM_PORTS-1:0][PKT_CNT_W-1:0]    r_pkt_count;
    logic [NUM_PORTS-1:0]                   w_cnt_inc;

    logic [NUM_PORTS-1:0]                   w_eligible;
    logic                                   w_found;
    logic [c_PORT_ID_W-1:0]                 w_pick;
    logic [c_PORT_ID_W-1:0]                 w_idx;

    logic                                   w_in_valid;
    logic                                   w_skid_ready;
    logic                                   w_fire;
    logic [USER_METADATA_WIDTH-1:0]         w_meta;

    assign w_eligible = s_tvalid & port_enable;
    assign pkt_count  = r_pkt_count;

    // Round-robin search starting just after the previous winner.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_last_grant;
        w_idx   = r_last_grant;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            w_idx = c_PORT_ID_W'((int'(r_last_grant) + i) % NUM_PORTS);
            if (!w_found && w_eligible[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    assign w_in_valid = (r_state == PKT) && s_tvalid[r_grant];
    assign w_fire     = w_in_valid && w_skid_ready;

    always_comb begin
        s_tready = '0;
        if (r_state == PKT) begin
            s_tready[r_grant] = w_skid_ready;
        end
    end

    always_comb begin
        w_meta = s_meta[r_grant];
        w_meta[PORT_ID_LSB +: c_PORT_ID_W] = r_grant;
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_grant_nxt      = r_grant;
        w_last_grant_nxt = r_last_grant;
        w_first_nxt      = r_first;
        w_cnt_inc        = '0;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_grant_nxt      = w_pick;
                    w_last_grant_nxt = w_pick;
                    w_first_nxt      = 1'b1;
                    w_state_nxt      = PKT;
                end
            end
            PKT: begin
                if (w_fire) begin
                    w_first_nxt = 1'b0;
                    if (s_tlast[r_grant]) begin
                        w_cnt_inc[r_grant] = 1'b1;
                        w_state_nxt        = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_last_grant <= c_PORT_ID_W'(NUM_PORTS - 1);
            r_first      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_first      <= w_first_nxt;
        end
    end

    // Counters only write on increment so each keeps its value otherwise.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_pkt_count <= '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (w_cnt_inc[p]) begin
                    r_pkt_count[p] <= r_pkt_count[p] + PKT_CNT_W'(1);
                end
            end
        end
    end

    p4_router_axis_skid #(
        .META_W (USER_METADATA_WIDTH)
    ) u_skid (
        .clk            (clk),
        .aresetn        (aresetn),
        .i_s_valid      (w_in_valid),
        .o_s_ready      (w_skid_ready),
        .i_s_data       (s_tdata[r_grant]),
        .i_s_keep       (s_tkeep[r_grant]),
        .i_s_last       (s_tlast[r_grant]),
        .i_s_meta       (w_meta),
        .i_s_meta_valid (r_first),
        .o_m_valid      (m_tvalid),
        .i_m_ready      (m_tready),
        .o_m_data       (m_tdata),
        .o_m_keep       (m_tkeep),
        .o_m_last       (m_tlast),
        .o_m_meta       (m_meta),
        .o_m_meta_valid (m_meta_valid)
    );

endmodule
`default_nettype wire

// File: tb/tb_p4_router_ingress_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_p4_router_ingress_arbiter                                    |
// | Brief    : Scoreboard bench: per-port source queues, expected-beat queue,  |
// |            output monitor with stall-stability and bubble checks.          |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_p4_router_ingress_arbiter;

    localparam int NP = 4;
    localparam int MW = 19;

    typedef struct packed {
        logic [63:0]   d;
        logic [7:0]    k;
        logic          l;
        logic [MW-1:0] m;
        logic          mv;
    } beat_t;

    logic                   clk = 1'b0;
    logic                   aresetn;
    logic [NP-1:0][63:0]    s_tdata;
    logic [NP-1:0][7:0]     s_tkeep;
    logic [NP-1:0]          s_tlast;
    logic [NP-1:0]          s_tvalid;
    logic [NP-1:0]          s_tready;
    logic [NP-1:0][MW-1:0]  s_meta;
    logic [NP-1:0]          port_enable;
    logic [63:0]            m_tdata;
    logic [7:0]             m_tkeep;
    logic                   m_tlast;
    logic                   m_tvalid;
    logic                   m_tready;
    logic [MW-1:0]          m_meta;
    logic                   m_meta_valid;
    logic [NP-1:0][31:0]    pkt_count;

    beat_t src_q[NP][$];
    beat_t exp_q[$];
    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;
    bit    rnd_ready = 1'b0;
    bit    gap_chk   = 1'b0;
    int    last_hs   = -1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    p4_router_ingress_arbiter #(
        .NUM_PORTS           (NP),
        .USER_METADATA_WIDTH (MW),
        .PORT_ID_LSB         (0)
    ) dut (
        .clk          (clk),
        .aresetn      (aresetn),
        .s_tdata      (s_tdata),
        .s_tkeep      (s_tkeep),
        .s_tlast      (s_tlast),
        .s_tvalid     (s_tvalid),
        .s_tready     (s_tready),
        .s_meta       (s_meta),
        .port_enable  (port_enable),
        .m_tdata      (m_tdata),
        .m_tkeep      (m_tkeep),
        .m_tlast      (m_tlast),
        .m_tvalid     (m_tvalid),
        .m_tready     (m_tready),
        .m_meta       (m_meta),
        .m_meta_valid (m_meta_valid),
        .pkt_count    (pkt_count)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Source beats carry a tag in the upper word and the beat index below.
    // Expected first-beat metadata has its two LSBs replaced by the port index.
    task automatic send_pkt(input int p, input int n, input logic [MW-1:0] meta, input logic [31:0] tag);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.d  = {tag, 32'(i)};
            b.k  = (i == n - 1) ? 8'h0F : 8'hFF;
            b.l  = (i == n - 1);
            b.m  = meta;
            b.mv = 1'b0;
            src_q[p].push_back(b);
            b.m  = {meta[MW-1:2], 2'(p)};
            b.mv = (i == 0);
            exp_q.push_back(b);
        end
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        for (int p = 0; p < NP; p++) src_q[p].delete();
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1 aresetn = 1'b1;
    endtask

    task automatic wait_drain(input string name, input int maxc);
        int n = 0;
        while (exp_q.size() != 0 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        check(name, 128'(exp_q.size()), 128'd0);
        repeat (3) @(negedge clk);
    endtask

    // Source driver: handshake sampled mid-cycle, next beat presented after the edge.
    initial begin
        logic [NP-1:0] fire;
        s_tvalid = '0; s_tdata = '0; s_tkeep = '0; s_tlast = '0; s_meta = '0;
        m_tready = 1'b1;
        forever begin
            @(negedge clk);
            fire = s_tvalid & s_tready;
            @(posedge clk);
            #1;
            for (int p = 0; p < NP; p++) begin
                if (fire[p] && src_q[p].size() != 0) void'(src_q[p].pop_front());
                if (src_q[p].size() != 0) begin
                    s_tvalid[p] = 1'b1;
                    s_tdata[p]  = src_q[p][0].d;
                    s_tkeep[p]  = src_q[p][0].k;
                    s_tlast[p]  = src_q[p][0].l;
                    s_meta[p]   = src_q[p][0].m;
                end else begin
                    s_tvalid[p] = 1'b0;
                end
            end
            m_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output monitor.
    initial begin
        beat_t       e;
        bit          stall = 1'b0;
        logic [93:0] held  = '0;
        forever begin
            @(negedge clk);
            if (!aresetn) begin
                stall   = 1'b0;
                last_hs = -1;
            end else begin
                if (stall)
                    check("stall_hold", 128'({m_tvalid, m_tdata, m_tkeep, m_tlast, m_meta, m_meta_valid}), 128'(held));
                if (m_tvalid && m_tready) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_beat: got data %0h expected no beat", m_tdata);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_data", 128'(m_tdata), 128'(e.d));
                        check("beat_keep", 128'(m_tkeep), 128'(e.k));
                        check("beat_last", 128'(m_tlast), 128'(e.l));
                        check("meta_valid", 128'(m_meta_valid), 128'(e.mv));
                        if (e.mv) check("meta_value", 128'(m_meta), 128'(e.m));
                    end
                    if (gap_chk && last_hs >= 0) check("pkt_gap", 128'(cyc - last_hs), 128'd2);
                    last_hs = cyc;
                end
                stall = m_tvalid && !m_tready;
                held  = {m_tvalid, m_tdata, m_tkeep, m_tlast, m_meta, m_meta_valid};
            end
        end
    end

    initial begin
        int n;
        port_enable = '1;
        aresetn     = 1'b0;
        #2;
        check("rst_m_tvalid", 128'(m_tvalid), 128'd0);
        check("rst_s_tready", 128'(s_tready), 128'd0);
        check("rst_meta_valid", 128'(m_meta_valid), 128'd0);
        check("rst_pkt_count", 128'(pkt_count), 128'd0);
        do_reset();

        // Single 3-beat packet from port 2; first-beat meta 0x7FFF0 -> 0x7FFF2.
        send_pkt(2, 3, 19'h7FFF0, 32'hA2A2_0001);
        check("t1_exp_meta", 128'(exp_q[0].m), 128'h7FFF2);
        wait_drain("t1_drain", 50);
        check("t1_cnt2", 128'(pkt_count[2]), 128'd1);
        check("t1_cnt_other", 128'({pkt_count[3], pkt_count[1], pkt_count[0]}), 128'd0);

        // All four ports always requesting single-beat packets.
        do_reset();
        for (int r = 0; r < 100; r++)
            for (int p = 0; p < NP; p++)
                send_pkt(p, 1, 19'(r * 16 + p * 4), {8'(p), 24'(r)});
        gap_chk = 1'b1;
        wait_drain("t2_drain", 1200);
        gap_chk = 1'b0;
        for (int p = 0; p < NP; p++) check("t2_cnt", 128'(pkt_count[p]), 128'd100);

        // Five-beat packet on port 1 with random backpressure.
        rnd_ready = 1'b1;
        send_pkt(1, 5, 19'h12345, 32'hB1B1_0002);
        wait_drain("t3_drain", 200);
        rnd_ready = 1'b0;
        check("t3_cnt1", 128'(pkt_count[1]), 128'd101);

        // Disable port 0 mid-packet: packet completes, port 0 not regranted.
        do_reset();
        send_pkt(0, 4, 19'h00100, 32'hC0C0_0003);
        begin
            beat_t b;
            b = '{d: 64'hDEAD_0000_0000_0000, k: 8'hFF, l: 1'b1, m: '0, mv: 1'b0};
            src_q[0].push_back(b);
        end
        n = 0;
        while (!(s_tvalid[0] && s_tready[0]) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("t4_first_hs", 128'(n < 50), 128'd1);
        @(posedge clk);
        #1 port_enable[0] = 1'b0;
        send_pkt(1, 2, 19'h00200, 32'hC1C1_0004);
        wait_drain("t4_drain", 100);
        repeat (20) @(negedge clk);
        check("t4_p0_not_regranted", 128'(src_q[0].size()), 128'd1);
        check("t4_cnt0", 128'(pkt_count[0]), 128'd1);
        check("t4_cnt1", 128'(pkt_count[1]), 128'd1);
        port_enable = '1;

        // Reset asserted in the middle of a port 3 packet.
        do_reset();
        send_pkt(3, 6, 19'h00300, 32'hD3D3_0005);
        n = 0;
        while (exp_q.size() > 4 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("t5_progress", 128'(n < 50), 128'd1);
        @(posedge clk);
        #2 aresetn = 1'b0;
        #1;
        check("t5_m_tvalid", 128'(m_tvalid), 128'd0);
        check("t5_s_tready", 128'(s_tready), 128'd0);
        check("t5_pkt_count", 128'(pkt_count), 128'd0);
        do_reset();
        send_pkt(0, 2, 19'h00400, 32'hE0E0_0006);
        wait_drain("t5_drain", 50);
        check("t5_cnt0", 128'(pkt_count[0]), 128'd1);

        // Counter wrap at 2^32.
        @(negedge clk);
        force dut.r_pkt_count = {32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF};
        #1;
        release dut.r_pkt_count;
        #1;
        check("t6_preload", 128'(pkt_count[0]), 128'hFFFF_FFFF);
        send_pkt(0, 1, 19'h00500, 32'hF0F0_0007);
        wait_drain("t6_drain", 50);
        check("t6_wrap", 128'(pkt_count[0]), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
